// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NRD read ports, two write ports with write-through bypass,
// and a per-register busy scoreboard set at issue and cleared by tagged writebacks.
module regfile_mp_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                wclr0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                wclr1,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy_vec
);

    localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    // Nonzero and inside the implemented register range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != {AW{1'b0}}) && ({1'b0, a} < NREG_W);
    endfunction

    // Register array update; port 1 wins when both ports hit the same register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            regs_r[0] <= {XLEN{1'b0}};
            for (int i = 1; i < NREG; i++) begin
                if (we1 && (wa1 == AW'(i))) begin
                    regs_r[i] <= wd1;
                end else if (we0 && (wa0 == AW'(i))) begin
                    regs_r[i] <= wd0;
                end
            end
        end
    end

    // Scoreboard next state: clears from tagged writes, then issue set overrides.
    always_comb begin
        busy_nxt_s    = {NREG{1'b0}};
        busy_nxt_s[0] = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            busy_nxt_s[i] = (iss_valid && (iss_rd == AW'(i)))
                          | (busy_r[i]
                             & ~(we0 && wclr0 && (wa0 == AW'(i)))
                             & ~(we1 && wclr1 && (wa1 == AW'(i))));
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign addr_s = rd_addr[k*AW +: AW];

        // Read mux with write-through bypass; a clearing writeback hides the busy bit.
        always_comb begin
            data_s = {XLEN{1'b0}};
            busy_s = 1'b0;
            if (reset && addr_ok(addr_s)) begin
                if (we1 && (wa1 == addr_s)) begin
                    data_s = wd1;
                end else if (we0 && (wa0 == addr_s)) begin
                    data_s = wd0;
                end else begin
                    data_s = regs_r[addr_s];
                end
                busy_s = busy_r[addr_s]
                       && !(we1 && wclr1 && (wa1 == addr_s))
                       && !(we0 && wclr0 && (wa0 == addr_s));
            end else begin
                data_s = {XLEN{1'b0}};
                busy_s = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_s;
        assign rd_busy[k]              = busy_s;
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: a default 2-port build (a_*) and a 4-port,
// 16-register, 64-bit build (b_*) driven from one directed stimulus sequence.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_we0, a_wclr0, a_we1, a_wclr1, a_iss_valid;
    logic [4:0]  a_wa0, a_wa1, a_iss_rd;
    logic [31:0] a_wd0, a_wd1;
    logic [31:0] a_busy_vec;

    logic [15:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic         b_we0, b_wclr0, b_we1, b_wclr1, b_iss_valid;
    logic [3:0]   b_wa0, b_wa1, b_iss_rd;
    logic [63:0]  b_wd0, b_wd1;
    logic [15:0]  b_busy_vec;

    regfile_mp_sb dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .wclr0(a_wclr0),
        .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1), .wclr1(a_wclr1),
        .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .busy_vec(a_busy_vec)
    );

    regfile_mp_sb #(.XLEN(64), .NREG(16), .NRD(4)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .wclr0(b_wclr0),
        .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1), .wclr1(b_wclr1),
        .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .busy_vec(b_busy_vec)
    );

    typedef struct {
        string       name;
        int          cyc;
        int          inst;
        int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_vec
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_v(input string name, input int inst, input int kind,
                            input int port, input logic [63:0] val);
        exp_t e;
        e.name = name; e.cyc = cyc; e.inst = inst; e.kind = kind; e.port = port; e.val = val;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due in the current cycle away from the edge.
    always @(negedge clk) begin
        exp_t        it;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it  = sb.pop_front();
            act = 64'hx;
            if (it.inst == 0) begin
                case (it.kind)
                    0:       act = 64'(a_rd_data[it.port*32 +: 32]);
                    1:       act = 64'(a_rd_busy[it.port]);
                    default: act = 64'(a_busy_vec);
                endcase
            end else begin
                case (it.kind)
                    0:       act = b_rd_data[it.port*64 +: 64];
                    1:       act = 64'(b_rd_busy[it.port]);
                    default: act = 64'(b_busy_vec);
                endcase
            end
            checks++;
            if (act !== it.val) begin
                errors++;
                $display("FAIL %s (cycle %0d): got %h, expected %h", it.name, cyc, act, it.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we0 = 1'b0; a_we1 = 1'b0; a_wclr0 = 1'b0; a_wclr1 = 1'b0; a_iss_valid = 1'b0;
        a_wa0 = 5'd0; a_wa1 = 5'd0; a_wd0 = 32'd0; a_wd1 = 32'd0; a_iss_rd = 5'd0;
        b_we0 = 1'b0; b_we1 = 1'b0; b_wclr0 = 1'b0; b_wclr1 = 1'b0; b_iss_valid = 1'b0;
        b_wa0 = 4'd0; b_wa1 = 4'd0; b_wd0 = 64'd0; b_wd1 = 64'd0; b_iss_rd = 4'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        a_rd_addr = 10'd0;
        b_rd_addr = 16'd0;
        idle();
        tick();
        tick();

        // Reset: writes/issues in flight, then reset held two cycles.
        tick(); idle(); reset = 1'b1;
        a_we0 = 1'b1; a_wa0 = 5'd4; a_wd0 = 32'h0000_1234;
        a_iss_valid = 1'b1; a_iss_rd = 5'd4;
        expect_v("busy_vec_after_reset", 0, 2, 0, 64'h0);
        tick(); idle();
        a_we1 = 1'b1; a_wa1 = 5'd6; a_wd1 = 32'h0000_5678;
        a_iss_valid = 1'b1; a_iss_rd = 5'd6;
        a_rd_addr = {5'd0, 5'd4};
        expect_v("pre_reset_rd_x4", 0, 0, 0, 64'h1234);
        expect_v("pre_reset_busy_x4", 0, 1, 0, 64'h1);
        expect_v("pre_reset_rd_x0", 0, 0, 1, 64'h0);
        tick(); idle(); reset = 1'b0;
        a_we0 = 1'b1; a_wa0 = 5'd4; a_wd0 = 32'h0000_AAAA;
        a_iss_valid = 1'b1; a_iss_rd = 5'd7;
        a_rd_addr = {5'd6, 5'd4};
        expect_v("in_reset_rd0_no_bypass", 0, 0, 0, 64'h0);
        expect_v("in_reset_rd1", 0, 0, 1, 64'h0);
        expect_v("in_reset_busy0", 0, 1, 0, 64'h0);
        expect_v("busy_vec_before_reset_edge", 0, 2, 0, 64'h50);
        tick(); idle();
        expect_v("busy_vec_in_reset", 0, 2, 0, 64'h0);
        expect_v("in_reset_rd1_b", 0, 0, 1, 64'h0);
        tick(); idle(); reset = 1'b1;
        expect_v("post_reset_x4", 0, 0, 0, 64'h0);
        expect_v("post_reset_x6", 0, 0, 1, 64'h0);
        expect_v("post_reset_busy_vec", 0, 2, 0, 64'h0);

        // Same-cycle bypass, then stored value.
        tick(); idle();
        a_we0 = 1'b1; a_wa0 = 5'd5; a_wd0 = 32'hDEAD_BEEF;
        a_rd_addr = {5'd0, 5'd5};
        expect_v("bypass_x5", 0, 0, 0, 64'hDEAD_BEEF);
        tick(); idle();
        expect_v("stored_x5", 0, 0, 0, 64'hDEAD_BEEF);

        // Dual write to x7: port 1 wins; writes to x0 are dropped.
        tick(); idle();
        a_we0 = 1'b1; a_wa0 = 5'd7; a_wd0 = 32'h11;
        a_we1 = 1'b1; a_wa1 = 5'd7; a_wd1 = 32'h22;
        a_rd_addr = {5'd7, 5'd5};
        expect_v("dual_write_bypass_x7", 0, 0, 1, 64'h22);
        tick(); idle();
        a_we0 = 1'b1; a_wa0 = 5'd0; a_wd0 = 32'hFFFF_FFFF;
        a_rd_addr = {5'd7, 5'd0};
        expect_v("dual_write_stored_x7", 0, 0, 1, 64'h22);
        expect_v("x0_write_bypass", 0, 0, 0, 64'h0);
        tick(); idle();
        expect_v("x0_after_write", 0, 0, 0, 64'h0);

        // Issue sets busy; clearing writeback hides it in the same cycle.
        tick(); idle();
        a_iss_valid = 1'b1; a_iss_rd = 5'd9;
        tick(); idle();
        a_we1 = 1'b1; a_wa1 = 5'd9; a_wd1 = 32'h99; a_wclr1 = 1'b1;
        a_rd_addr = {5'd9, 5'd9};
        expect_v("busy_vec_x9_set", 0, 2, 0, 64'h200);
        expect_v("rd_busy0_x9_clearing", 0, 1, 0, 64'h0);
        expect_v("rd_busy1_x9_clearing", 0, 1, 1, 64'h0);
        expect_v("rd_x9_bypass", 0, 0, 0, 64'h99);
        tick(); idle();
        expect_v("busy_vec_x9_cleared", 0, 2, 0, 64'h0);
        expect_v("rd_x9_stored", 0, 0, 0, 64'h99);

        // Set wins over clear; a non-clearing write leaves busy alone.
        tick(); idle();
        a_iss_valid = 1'b1; a_iss_rd = 5'd3;
        tick(); idle();
        a_iss_valid = 1'b1; a_iss_rd = 5'd3;
        a_we0 = 1'b1; a_wa0 = 5'd3; a_wd0 = 32'h33; a_wclr0 = 1'b1;
        expect_v("busy_vec_x3_set", 0, 2, 0, 64'h8);
        tick(); idle();
        a_we1 = 1'b1; a_wa1 = 5'd3; a_wd1 = 32'h44; a_wclr1 = 1'b0;
        a_rd_addr = {5'd0, 5'd3};
        expect_v("busy_vec_set_wins", 0, 2, 0, 64'h8);
        expect_v("rd_busy_x3_noclr", 0, 1, 0, 64'h1);
        expect_v("rd_x3_bypass_noclr", 0, 0, 0, 64'h44);
        tick(); idle();
        expect_v("busy_vec_x3_noclr", 0, 2, 0, 64'h8);
        expect_v("rd_x3_stored", 0, 0, 0, 64'h44);

        // Wide build: four ports, then reset mid-sequence with busy bits pending.
        tick(); idle();
        b_we0 = 1'b1; b_wa0 = 4'd1; b_wd0 = 64'h1111_2222_3333_4444;
        b_we1 = 1'b1; b_wa1 = 4'd2; b_wd1 = 64'hA5A5_5A5A_0F0F_F0F0;
        b_iss_valid = 1'b1; b_iss_rd = 4'd15;
        tick(); idle();
        b_we0 = 1'b1; b_wa0 = 4'd15; b_wd0 = 64'hFFFF_0000_FFFF_0001;
        b_iss_valid = 1'b1; b_iss_rd = 4'd1;
        b_rd_addr = {4'd15, 4'd1, 4'd2, 4'd1};
        expect_v("b_busy_vec_x15", 1, 2, 0, 64'h8000);
        expect_v("b_rd0_x1", 1, 0, 0, 64'h1111_2222_3333_4444);
        expect_v("b_rd1_x2", 1, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0);
        expect_v("b_rd2_x1", 1, 0, 2, 64'h1111_2222_3333_4444);
        expect_v("b_rd3_x15_bypass", 1, 0, 3, 64'hFFFF_0000_FFFF_0001);
        expect_v("b_busy3_x15", 1, 1, 3, 64'h1);
        tick(); idle();
        expect_v("b_busy_vec_x1_x15", 1, 2, 0, 64'h8002);
        expect_v("b_rd3_x15_stored", 1, 0, 3, 64'hFFFF_0000_FFFF_0001);
        expect_v("b_rd1_x2_stored", 1, 0, 1, 64'hA5A5_5A5A_0F0F_F0F0);
        expect_v("b_busy0_x1", 1, 1, 0, 64'h1);
        tick(); idle(); reset = 1'b0;
        expect_v("b_rd0_in_reset", 1, 0, 0, 64'h0);
        expect_v("b_busy3_in_reset", 1, 1, 3, 64'h0);
        tick(); idle(); reset = 1'b1;
        expect_v("b_busy_vec_reset", 1, 2, 0, 64'h0);
        expect_v("a_busy_vec_reset", 0, 2, 0, 64'h0);
        expect_v("b_rd0_x1_reset", 1, 0, 0, 64'h0);
        expect_v("b_rd3_x15_reset", 1, 0, 3, 64'h0);

        tick(); idle();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
